// File: rtl/seg7_shift_out.sv
// seg7_shift_out
//
// Serializes one 8-bit display frame {dp, segments[6:0]} onto a 3-wire
// interface for an external 74HC595-style shift register. The frame goes out
// MSB first: dp first, segment a last. A latch pulse then transfers it to the
// storage register.
//
// Parameters:
//   CLK_DIV    half-period of sr_clk in clk cycles (1..255)
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   segments   segment pattern, bit 0 = segment a
//   dp         decimal point
//   in_valid   frame offered
//   in_ready   block idle; frame accepted when in_valid && in_ready
//   sr_data    serial data to the shift register
//   sr_clk     shift clock (external device samples on rising edge)
//   sr_latch   storage-register latch pulse, active-high
//   done       one-cycle pulse when a frame has been latched
//
// Optional feature (macro SEG7_SHIFT_SKIP_EN):
//   The block remembers the last latched word. An accepted word equal to it
//   completes on the next edge without touching the 3-wire interface.
//   Reset clears the remembered word to 0.

module seg7_shift_out #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] segments,
    input  logic       dp,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       sr_data,
    output logic       sr_clk,
    output logic       sr_latch,
    output logic       done
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SHIFT_LO = 3'd1;
    localparam logic [2:0] ST_SHIFT_HI = 3'd2;
    localparam logic [2:0] ST_LATCH    = 3'd3;
    localparam logic [2:0] ST_SKIP     = 3'd4;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [2:0] state;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] frame_word;
    logic       phase_end;
    logic       skip_hit;

    assign frame_word = {dp, segments};
    assign phase_end  = (div_cnt == DIV_LAST);

`ifdef SEG7_SHIFT_SKIP_EN
    logic [7:0] last_word;

    assign skip_hit = (frame_word == last_word);

    // shreg is rotated once per high phase, so after the 8th high phase it
    // holds the original frame again and can be copied straight into
    // last_word when the latch phase finishes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_word <= 8'h00;
        end else if (state == ST_LATCH && phase_end) begin
            last_word <= shreg;
        end
    end
`else
    assign skip_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            div_cnt  <= 8'h00;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            in_ready <= 1'b1;
            sr_data  <= 1'b0;
            sr_clk   <= 1'b0;
            sr_latch <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (skip_hit) begin
                            state <= ST_SKIP;
                        end else begin
                            state   <= ST_SHIFT_LO;
                            shreg   <= frame_word;
                            sr_data <= frame_word[7];
                            bit_cnt <= 3'd0;
                            div_cnt <= 8'h00;
                        end
                    end
                end

                ST_SHIFT_LO: begin
                    if (phase_end) begin
                        state   <= ST_SHIFT_HI;
                        sr_clk  <= 1'b1;
                        div_cnt <= 8'h00;
                    end else begin
                        div_cnt <= div_cnt + 8'h01;
                    end
                end

                ST_SHIFT_HI: begin
                    if (phase_end) begin
                        sr_clk  <= 1'b0;
                        div_cnt <= 8'h00;
                        // Rotate rather than shift so the frame survives
                        // intact for the last-word register.
                        shreg   <= {shreg[6:0], shreg[7]};
                        if (bit_cnt == 3'd7) begin
                            state    <= ST_LATCH;
                            sr_data  <= 1'b0;
                            sr_latch <= 1'b1;
                        end else begin
                            state   <= ST_SHIFT_LO;
                            sr_data <= shreg[6];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'h01;
                    end
                end

                ST_LATCH: begin
                    if (phase_end) begin
                        state    <= ST_IDLE;
                        sr_latch <= 1'b0;
                        div_cnt  <= 8'h00;
                        done     <= 1'b1;
                        in_ready <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 8'h01;
                    end
                end

                // Repeat of the displayed word: finish without shifting.
                ST_SKIP: begin
                    state    <= ST_IDLE;
                    done     <= 1'b1;
                    in_ready <= 1'b1;
                end

                default: begin
                    state    <= ST_IDLE;
                    div_cnt  <= 8'h00;
                    in_ready <= 1'b1;
                    sr_data  <= 1'b0;
                    sr_clk   <= 1'b0;
                    sr_latch <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_shift_out.sv
// tb_seg7_shift_out
//
// Directed bench for seg7_shift_out with CLK_DIV = 2. Monitors count sr_clk
// rises (capturing sr_data at each rise) and sr_latch high cycles; each
// scenario compares deltas of those against hand-computed values.

module tb_seg7_shift_out;

    localparam int CLK_DIV = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] segments = 7'h00;
    logic       dp = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       sr_data;
    logic       sr_clk;
    logic       sr_latch;
    logic       done;

    int checks = 0;
    int failures = 0;

    int         rises = 0;
    logic [7:0] bits = 8'h00;
    int         latch_cyc = 0;

    seg7_shift_out #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .segments (segments),
        .dp       (dp),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sr_data  (sr_data),
        .sr_clk   (sr_clk),
        .sr_latch (sr_latch),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge sr_clk) begin
        rises <= rises + 1;
        bits  <= {bits[6:0], sr_data};
    end

    always @(posedge clk) begin
        if (sr_latch) latch_cyc <= latch_cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word and return #1 after the accept edge with in_valid dropped.
    task automatic accept(input logic [7:0] w);
        int g;
        segments = w[6:0];
        dp       = w[7];
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 400) begin
            tick();
            g++;
        end
        chk("accept_wait", 32'(g < 400), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Edges from the current edge to the done edge.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!done && lat < 400);
    endtask

    initial begin
        int lat;
        int r0;
        int l0;
        int n;
        int g;
        logic prev;

        // Asynchronous reset, checked before any clock edge
        #1 reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sr_data",  32'(sr_data),  32'd0);
        chk("rst_sr_clk",   32'(sr_clk),   32'd0);
        chk("rst_sr_latch", 32'(sr_latch), 32'd0);
        chk("rst_done",     32'(done),     32'd0);
        #10 reset = 1'b1;
        tick();
        tick();

        // Single frame 0x3F: bits 0,0,1,1,1,1,1,1
        r0 = rises;
        l0 = latch_cyc;
        accept(8'h3F);
        wait_done(lat);
        chk("single_lat",   32'(lat), 32'd34);
        chk("single_rises", 32'(rises - r0), 32'd8);
        chk("single_bits",  32'(bits), 32'h3F);
        chk("single_latch", 32'(latch_cyc - l0), 32'd2);
        chk("single_ready", 32'(in_ready), 32'd1);
        tick();
        chk("single_done_1cyc", 32'(done), 32'd0);

        // Back-to-back with in_valid held: 0x06 then 0xDB
        r0 = rises;
        segments = 7'h06;
        dp       = 1'b0;
        in_valid = 1'b1;
        tick();
        segments = 7'h5B;
        dp       = 1'b1;
        n = 0;
        do begin
            prev = in_ready;
            tick();
            n++;
        end while (!prev && n < 100);
        chk("b2b_period",     32'(n), 32'd35);
        chk("b2b_first_rise", 32'(rises - r0), 32'd8);
        chk("b2b_first_bits", 32'(bits), 32'h06);
        in_valid = 1'b0;
        r0 = rises;
        wait_done(lat);
        chk("b2b_second_lat",   32'(lat), 32'd34);
        chk("b2b_second_rises", 32'(rises - r0), 32'd8);
        chk("b2b_second_bits",  32'(bits), 32'hDB);

        // Busy drop: 0x7F offered for one cycle while busy is ignored
        r0 = rises;
        accept(8'h06);
        repeat (5) tick();
        segments = 7'h7F;
        dp       = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done(lat);
        chk("busy_lat",   32'(lat), 32'd28);
        chk("busy_rises", 32'(rises - r0), 32'd8);
        chk("busy_bits",  32'(bits), 32'h06);
        repeat (40) tick();
        chk("busy_no_second",   32'(rises - r0), 32'd8);
        chk("busy_ready_after", 32'(in_ready), 32'd1);

        // Mid-frame reset after the 3rd rise of 0xE0 (sr_clk and sr_data high)
        r0 = rises;
        l0 = latch_cyc;
        accept(8'hE0);
        g = 0;
        while ((rises - r0) < 3 && g < 200) begin
            tick();
            g++;
        end
        chk("mid_third_rise", 32'(rises - r0), 32'd3);
        reset = 1'b0;
        #2;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_sr_data",  32'(sr_data),  32'd0);
        chk("mid_rst_sr_clk",   32'(sr_clk),   32'd0);
        chk("mid_rst_sr_latch", 32'(sr_latch), 32'd0);
        chk("mid_rst_done",     32'(done),     32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("mid_no_latch", 32'(latch_cyc - l0), 32'd0);

        r0 = rises;
        l0 = latch_cyc;
        accept(8'h66);
        wait_done(lat);
        chk("post_rst_lat",   32'(lat), 32'd34);
        chk("post_rst_rises", 32'(rises - r0), 32'd8);
        chk("post_rst_bits",  32'(bits), 32'h66);
        chk("post_rst_latch", 32'(latch_cyc - l0), 32'd2);

        // Same word 0x4F twice
        accept(8'h4F);
        wait_done(lat);
        chk("rep_first_lat", 32'(lat), 32'd34);
        r0 = rises;
        l0 = latch_cyc;
        accept(8'h4F);
        wait_done(lat);
`ifdef SEG7_SHIFT_SKIP_EN
        chk("rep_skip_lat",   32'(lat), 32'd1);
        chk("rep_skip_rises", 32'(rises - r0), 32'd0);
        chk("rep_skip_latch", 32'(latch_cyc - l0), 32'd0);
`else
        chk("rep_full_lat",   32'(lat), 32'd34);
        chk("rep_full_rises", 32'(rises - r0), 32'd8);
        chk("rep_full_bits",  32'(bits), 32'h4F);
        chk("rep_full_latch", 32'(latch_cyc - l0), 32'd2);
`endif
        chk("rep_ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_shift_out.md
# seg7_shift_out

- Serializer stage downstream of the seven-segment seconds counter.
- Accepts one 8-bit display frame per handshake: 7 segment bits from the digit decoder plus a decimal point.
- Shifts the frame out on a 3-wire interface (data, shift clock, latch) to an external 74HC595-style shift register that drives the display.
- Lets the design drive a display through a few pins with a paced, glitch-free update.

## Interface

Parameters:

- CLK_DIV, default 4: half-period of `sr_clk`, in `clk` cycles; legal range 1..255.

Ports:

- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- segments  input  7  segment pattern, bit 0 = segment a.
- dp  input  1  decimal point.
- in_valid  input  1  frame offered.
- in_ready  output  1  block idle; frame accepted on an edge where `in_valid && in_ready`.
- sr_data  output  1  serial data to the shift register.
- sr_clk  output  1  shift clock; the external device samples on the rising edge.
- sr_latch  output  1  storage-register latch pulse, active-high.
- done  output  1  one-cycle pulse when a frame has been latched.

## Operation

- Frame word = {dp, segments[6:0]}; shifted MSB first (dp first, segment a last).
- States:
  - IDLE
  - SHIFT_LO: `sr_clk` low, `sr_data` driven.
  - SHIFT_HI: `sr_clk` high.
  - LATCH: `sr_latch` high, `sr_clk` low.
- IDLE -> SHIFT_LO on accept:
  - Word captured into an 8-bit shift register.
  - Bit counter cleared.
  - `sr_data` = word[7] on the same edge.
- SHIFT_LO -> SHIFT_HI after CLK_DIV cycles.
- SHIFT_HI -> SHIFT_LO after CLK_DIV cycles, with the shift register advanced and `sr_data` = next bit.
  - Exception: after the 8th high phase, go to LATCH with `sr_data` = 0.
- LATCH -> IDLE after CLK_DIV cycles; `done` = 1 and `in_ready` = 1 on that edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Divider counter is 8 bits wide and reloads to 0 on every phase change.
- `in_valid` while not ready is ignored; there is no queueing, and `segments`/`dp` are sampled only at accept.
- Reset values: `in_ready` = 1, `sr_data` = 0, `sr_clk` = 0, `sr_latch` = 0, `done` = 0; state IDLE; shift register and last-word register = 0.
- Reset mid-frame:
  - All outputs go to their reset values immediately (asynchronous).
  - The partial frame is discarded and `sr_latch` is never raised for it.
  - The external register retains its previous latched value.

## Timing

- Accept edge to first `sr_clk` rise: CLK_DIV cycles.
- `sr_data` is stable for the full CLK_DIV cycles before and after each `sr_clk` rising edge.
- Frame duration, accept edge to `done` edge: 17*CLK_DIV cycles (16 shift phases + 1 latch phase).
- `sr_latch` is high for exactly CLK_DIV cycles; `sr_clk` is low throughout.
- Earliest next accept is the edge after `done`. Back-to-back period is 17*CLK_DIV + 1 cycles.
- `done` is high for exactly one cycle, coincident with the first cycle `in_ready` is high again.

## Configuration

- Macro: SEG7_SHIFT_SKIP_EN.
- Defined:
  - Block keeps a last-latched-word register, updated on each `done`.
  - An accepted word equal to that register skips shifting: state IDLE -> LATCH-free completion.
  - `done` pulses on the edge after accept, and `in_ready` is low for exactly that one cycle.
  - `sr_clk`, `sr_data` and `sr_latch` do not toggle.
  - Reset clears the register to 0, so a first frame of 0x00 is skipped.
- Undefined: every accepted word is shifted and latched; no comparison register exists.

## Test plan

- Reset: hold `reset` = 0 mid-run -> `in_ready` = 1, `sr_clk` = `sr_data` = `sr_latch` = `done` = 0 with no clock edge needed.
- Single frame, CLK_DIV = 2: segments = 7'h3F, dp = 0 ->
  - `sr_data` sampled at the 8 `sr_clk` rises = 0,0,1,1,1,1,1,1.
  - `sr_latch` high for 2 cycles.
  - `done` 34 cycles after the accept edge.
- Back-to-back, CLK_DIV = 2: `in_valid` held, words 0x06 then 0xDB -> second accept 35 cycles after the first; the second frame's bits are 1,1,0,1,1,0,1,1.
- Busy drop: present 0x7F during a frame with `in_valid` for 1 cycle while `in_ready` = 0 -> no second frame and no extra `sr_clk` edges.
- Mid-frame reset after the 3rd `sr_clk` rise -> `sr_latch` never asserted; a following frame of 0x66 shifts cleanly with exactly 8 rises.
- SEG7_SHIFT_SKIP_EN, CLK_DIV = 2: send 0x4F twice ->
  - With macro: the second `done` arrives 1 cycle after accept with zero `sr_clk` edges.
  - Without macro: the second frame takes the full 34 cycles.
